ex_hazard_fwd_ctrl: RTL and testbench
=====================================

Name: ex_hazard_fwd_ctrl

Overview:
- Parametrised successor to the EX-stage forwarding logic. Selects per-operand forwarding sources from N downstream pipeline stages and detects load-use hazards.
- Adds a register scoreboard for long-latency ops (divider, missed loads) and generates a stall. It also keeps a saturating stall-cycle performance counter.
- Sits between decode/EX pipeline registers and the EX operand muxes. It is decoupled from opcodes: the EX decoder supplies operand-use flags.

Parameters:
- NSRC, 2, number of source operands checked per EX instruction.
- NSTAGES, 2, forwarding source stages after EX (stage 1 = EX/MEM, stage 2 = MEM/WB, ...).
- REG_W, 5, register index width.
- SB_DEPTH, 4, max outstanding long-latency ops (total and per register).
- PERF_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX holds a real instruction
- ex_rs  in  NSRC x REG_W  EX source register indices
- ex_rs_used  in  NSRC  operand actually read by the instruction
- stg_wr_en  in  NSTAGES  stage k will write rd
- stg_rd  in  NSTAGES x REG_W  stage k destination
- stg_data_rdy  in  NSTAGES  stage k result valid in its forward latch (0 for a load in EX/MEM)
- lo_issue  in  1  long op issued this cycle (one-cycle pulse per op)
- lo_rd  in  REG_W  long op destination
- lo_done  in  1  long op result written this cycle
- lo_done_rd  in  REG_W  completing destination
- fwd_sel  out  NSRC x $clog2(NSTAGES+1)  0 = register file/ID-EX value, k = stage k
- stall  out  1  freeze IF/ID/EX, bubble into EX/MEM
- lo_full  out  1  outstanding count == SB_DEPTH
- sb_err  out  1  sticky protocol error
- stall_cnt  out  PERF_W  cycles with stall=1

Behaviour:
- Forwarding (combinational):
  - For each operand i with ex_valid & ex_rs_used[i] & ex_rs[i]!=0, search stages 1..NSTAGES for stg_wr_en[k] & stg_rd[k]==ex_rs[i].
  - The lowest k (youngest) wins, so fwd_sel[i]=k. With no match, fwd_sel[i]=0.
  - Unused operands, rs=0, or ex_valid=0 give fwd_sel=0.
- Load-use hazard: if the winning stage has stg_data_rdy[k]=0, stall=1. Older matching stages are never used instead.
- Scoreboard:
  - pend_cnt[r] is a per-register counter, 0..SB_DEPTH. out_cnt is the total outstanding count.
  - Scoreboard stall: operand i is valid/used, rs!=0, has no stage match, and pend_cnt[rs]!=0, so stall=1.
  - A stage match takes precedence because it carries the youngest value.
  - The stall uses registered counters only. lo_done in cycle t releases the stall in t+1.
- Issue, at the clk edge:
  - lo_issue & lo_rd!=0 & !lo_full: pend_cnt[lo_rd]++ and out_cnt++.
  - lo_rd=0: ignored, not counted.
  - lo_issue while lo_full, or with pend_cnt[lo_rd]==SB_DEPTH: ignored, sb_err<=1.
- Done, at the clk edge:
  - lo_done & pend_cnt[lo_done_rd]!=0: decrement the counter and out_cnt.
  - Done on a zero counter: ignored, sb_err<=1.
- Simultaneous issue and done:
  - Same register: counter unchanged, out_cnt unchanged.
  - Different registers: both applied.
  - lo_full is evaluated on the pre-edge out_cnt; done does not free a slot for a same-cycle issue.
- Counters: stall_cnt increments every cycle stall=1 and saturates at all-ones. sb_err clears only on rst.
- Reset (synchronous): all pend_cnt, out_cnt, stall_cnt and sb_err go to 0. lo_full=0.
  - Combinational outputs follow their inputs, with scoreboard terms inactive.
  - Reset mid-operation discards all outstanding entries; any later done is flagged as an error.
- Output latency: fwd_sel and stall are combinational in the same cycle. Scoreboard updates take 1 cycle.

Decomposition:
- Add to rv32i_types: typedef fwd_sel_t (width $clog2(NSTAGES+1)); constants FWD_REGFILE=0, FWD_EX_MEM=1, FWD_MEM_WB=2.
- Sub-module lo_scoreboard holds pend_cnt, out_cnt, lo_full and sb_err, and outputs a per-register pending vector.
- The top level holds the priority search, stall combine and perf counter.

Test Plan:
- EX add rs1=x5, rs2=x5; stage1 rd=x5 rdy=1; stage2 rd=x5 → fwd_sel={1,1}, stall=0.
- Stage1 is a load, rd=x7, rdy=0; EX rs1=x7 → stall=1 and stall_cnt 0→1. Next cycle stage2 rd=x7 rdy=1 → fwd_sel[0]=2, stall=0.
- lo_issue rd=x9; next cycle EX rs2=x9, no stage match → stall=1 for 3 cycles. lo_done rd=x9 at cycle 3 → stall=0 at cycle 4; stall_cnt=3.
- Four issues to x1..x4 → lo_full=1. A fifth issue is ignored and sb_err=1. Issue x1 plus done x1 in the same cycle → pend_cnt[x1] stays 1.
- EX rs1=x0 with stage1 rd=x0 wr_en=1, and lo_issue rd=x0 → fwd_sel=0, no stall, out_cnt unchanged.
- Two issues to x6, rst mid-stream → counters 0, stall=0. A following lo_done rd=x6 → sb_err=1.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: EX operand forwarding source encodings.
package rv32i_types;

    localparam int NSTAGES_DEF = 2;
    localparam int FWD_W       = $clog2(NSTAGES_DEF + 1);

    typedef logic [FWD_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = fwd_sel_t'(0);
    localparam fwd_sel_t FWD_EX_MEM  = fwd_sel_t'(1);
    localparam fwd_sel_t FWD_MEM_WB  = fwd_sel_t'(2);

endpackage

// File: rtl/lo_scoreboard.sv
// Long-latency op scoreboard: per-register pending counts, total
// outstanding count, full flag and sticky protocol error.
module lo_scoreboard
    import rv32i_types::*;
#(
    parameter int REG_W    = 5,
    parameter int SB_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_lo_issue,
    input  logic [REG_W-1:0]        i_lo_rd,
    input  logic                    i_lo_done,
    input  logic [REG_W-1:0]        i_lo_done_rd,
    output logic                    o_lo_full,
    output logic                    o_sb_err,
    output logic [(1<<REG_W)-1:0]   o_pend
);

    localparam int NREG = 1 << REG_W;
    localparam int CW   = $clog2(SB_DEPTH + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH = cnt_t'(SB_DEPTH);

    cnt_t r_pend [NREG];
    cnt_t r_out;
    logic r_err;

    logic w_full;
    logic w_iss_ok;
    logic w_iss_err;
    logic w_dn_ok;
    logic w_dn_err;
    logic w_same;

    assign w_full    = (r_out == DEPTH);
    assign w_iss_ok  = i_lo_issue && (i_lo_rd != '0) && !w_full
                       && (r_pend[i_lo_rd] != DEPTH);
    assign w_iss_err = i_lo_issue && (i_lo_rd != '0) && !w_iss_ok;
    assign w_dn_ok   = i_lo_done && (r_pend[i_lo_done_rd] != '0);
    assign w_dn_err  = i_lo_done && !w_dn_ok;
    // Issue and done on the same register cancel out.
    assign w_same    = w_iss_ok && w_dn_ok && (i_lo_rd == i_lo_done_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_pend[r] <= '0;
            end
            r_out <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_iss_ok && !w_same) begin
                r_pend[i_lo_rd] <= r_pend[i_lo_rd] + cnt_t'(1);
            end
            if (w_dn_ok && !w_same) begin
                r_pend[i_lo_done_rd] <= r_pend[i_lo_done_rd] - cnt_t'(1);
            end
            if (w_iss_ok && !w_dn_ok) begin
                r_out <= r_out + cnt_t'(1);
            end else if (w_dn_ok && !w_iss_ok) begin
                r_out <= r_out - cnt_t'(1);
            end
            if (w_iss_err || w_dn_err) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            o_pend[r] = (r_pend[r] != '0) && !rst;
        end
    end

    assign o_lo_full = w_full && !rst;
    assign o_sb_err  = r_err;

endmodule

// File: rtl/ex_hazard_fwd_ctrl.sv
// EX-stage operand forwarding select, load-use / scoreboard stall
// and saturating stall-cycle counter.
module ex_hazard_fwd_ctrl
    import rv32i_types::*;
#(
    parameter int NSRC     = 2,
    parameter int NSTAGES  = 2,
    parameter int REG_W    = 5,
    parameter int SB_DEPTH = 4,
    parameter int PERF_W   = 32
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        ex_valid,
    input  logic [NSRC-1:0][REG_W-1:0]                  ex_rs,
    input  logic [NSRC-1:0]                             ex_rs_used,
    input  logic [NSTAGES-1:0]                          stg_wr_en,
    input  logic [NSTAGES-1:0][REG_W-1:0]               stg_rd,
    input  logic [NSTAGES-1:0]                          stg_data_rdy,
    input  logic                                        lo_issue,
    input  logic [REG_W-1:0]                            lo_rd,
    input  logic                                        lo_done,
    input  logic [REG_W-1:0]                            lo_done_rd,
    output logic [NSRC-1:0][$clog2(NSTAGES+1)-1:0]      fwd_sel,
    output logic                                        stall,
    output logic                                        lo_full,
    output logic                                        sb_err,
    output logic [PERF_W-1:0]                           stall_cnt
);

    localparam int SW = $clog2(NSTAGES + 1);

    logic [(1<<REG_W)-1:0]  w_pend;
    logic [NSRC-1:0][SW-1:0] w_sel;
    logic                   w_stall;
    logic [PERF_W-1:0]      r_stall_cnt;

    lo_scoreboard #(
        .REG_W    (REG_W),
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .i_lo_issue   (lo_issue),
        .i_lo_rd      (lo_rd),
        .i_lo_done    (lo_done),
        .i_lo_done_rd (lo_done_rd),
        .o_lo_full    (lo_full),
        .o_sb_err     (sb_err),
        .o_pend       (w_pend)
    );

    always_comb begin
        logic hit;
        logic rdy;
        w_stall = 1'b0;
        hit     = 1'b0;
        rdy     = 1'b1;
        for (int i = 0; i < NSRC; i++) begin
            w_sel[i] = SW'(FWD_REGFILE);
            hit      = 1'b0;
            rdy      = 1'b1;
            if (ex_valid && ex_rs_used[i] && (ex_rs[i] != '0)) begin
                // Scan oldest to youngest so the youngest match wins.
                for (int k = NSTAGES - 1; k >= 0; k--) begin
                    if (stg_wr_en[k] && (stg_rd[k] == ex_rs[i])) begin
                        w_sel[i] = SW'(k + 1);
                        hit      = 1'b1;
                        rdy      = stg_data_rdy[k];
                    end
                end
                if (hit && !rdy) begin
                    w_stall = 1'b1;
                end
                if (!hit && w_pend[ex_rs[i]]) begin
                    w_stall = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign fwd_sel   = w_sel;
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ex_hazard_fwd_ctrl.sv
// Directed self-checking bench for ex_hazard_fwd_ctrl.
module tb_ex_hazard_fwd_ctrl;

    logic             clk;
    logic             rst;
    logic             ex_valid;
    logic [1:0][4:0]  ex_rs;
    logic [1:0]       ex_rs_used;
    logic [1:0]       stg_wr_en;
    logic [1:0][4:0]  stg_rd;
    logic [1:0]       stg_data_rdy;
    logic             lo_issue;
    logic [4:0]       lo_rd;
    logic             lo_done;
    logic [4:0]       lo_done_rd;
    logic [1:0][1:0]  fwd_sel;
    logic             stall;
    logic             lo_full;
    logic             sb_err;
    logic [31:0]      stall_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    ex_hazard_fwd_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_rs        (ex_rs),
        .ex_rs_used   (ex_rs_used),
        .stg_wr_en    (stg_wr_en),
        .stg_rd       (stg_rd),
        .stg_data_rdy (stg_data_rdy),
        .lo_issue     (lo_issue),
        .lo_rd        (lo_rd),
        .lo_done      (lo_done),
        .lo_done_rd   (lo_done_rd),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .lo_full      (lo_full),
        .sb_err       (sb_err),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ex_valid     = 1'b0;
        ex_rs        = '0;
        ex_rs_used   = '0;
        stg_wr_en    = '0;
        stg_rd       = '0;
        stg_data_rdy = '0;
        lo_issue     = 1'b0;
        lo_rd        = '0;
        lo_done      = 1'b0;
        lo_done_rd   = '0;
    endtask

    task automatic issue(input logic [4:0] rd);
        lo_issue = 1'b1;
        lo_rd    = rd;
        tick();
        lo_issue = 1'b0;
    endtask

    task automatic done(input logic [4:0] rd);
        lo_done    = 1'b1;
        lo_done_rd = rd;
        tick();
        lo_done = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [4:0] rs,
                         input logic exp);
        ex_valid   = 1'b1;
        ex_rs[0]   = rs;
        ex_rs_used = 2'b01;
        #1;
        chk(tag, 32'(stall), 32'(exp));
        ex_valid   = 1'b0;
        ex_rs_used = 2'b00;
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_full", 32'(lo_full), 32'd0);
        chk("rst_err", 32'(sb_err), 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        // Both operands x5, both stages write x5.
        ex_valid     = 1'b1;
        ex_rs        = {5'd5, 5'd5};
        ex_rs_used   = 2'b11;
        stg_wr_en    = 2'b11;
        stg_rd       = {5'd5, 5'd5};
        stg_data_rdy = 2'b11;
        #1;
        chk("fwd_both_s1", 32'(fwd_sel), 32'h5);
        chk("fwd_both_stall", 32'(stall), 32'd0);
        stg_wr_en = 2'b10;
        #1;
        chk("fwd_both_s2", 32'(fwd_sel), 32'ha);
        stg_wr_en  = 2'b11;
        ex_rs_used = 2'b01;
        #1;
        chk("fwd_unused", 32'(fwd_sel), 32'h1);
        ex_valid = 1'b0;
        #1;
        chk("fwd_invalid", 32'(fwd_sel), 32'h0);
        clr();
        tick();

        // Load in EX/MEM, older copy in MEM/WB must not be used.
        ex_valid     = 1'b1;
        ex_rs        = {5'd3, 5'd7};
        ex_rs_used   = 2'b01;
        stg_wr_en    = 2'b11;
        stg_rd       = {5'd7, 5'd7};
        stg_data_rdy = 2'b10;
        #1;
        chk("lu_older_sel", 32'(fwd_sel), 32'h1);
        chk("lu_older_stall", 32'(stall), 32'd1);
        stg_wr_en = 2'b01;
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_cnt", stall_cnt, 32'd1);
        stg_wr_en    = 2'b10;
        stg_data_rdy = 2'b10;
        #1;
        chk("lu_wb_sel", 32'(fwd_sel), 32'h2);
        chk("lu_wb_stall", 32'(stall), 32'd0);
        tick();
        chk("lu_cnt_hold", stall_cnt, 32'd1);
        clr();

        // Scoreboard stall on x9 released one cycle after done.
        issue(5'd9);
        ex_valid   = 1'b1;
        ex_rs[1]   = 5'd9;
        ex_rs_used = 2'b10;
        #1;
        chk("sb_c1", 32'(stall), 32'd1);
        tick();
        chk("sb_c2", 32'(stall), 32'd1);
        tick();
        lo_done    = 1'b1;
        lo_done_rd = 5'd9;
        #1;
        chk("sb_c3", 32'(stall), 32'd1);
        tick();
        lo_done = 1'b0;
        #1;
        chk("sb_c4", 32'(stall), 32'd0);
        chk("sb_cnt", stall_cnt, 32'd4);
        tick();
        chk("sb_cnt_hold", stall_cnt, 32'd4);
        clr();

        // Fill the scoreboard.
        issue(5'd1);
        issue(5'd2);
        issue(5'd3);
        chk("fill3_full", 32'(lo_full), 32'd0);
        issue(5'd4);
        chk("fill4_full", 32'(lo_full), 32'd1);
        chk("fill4_err", 32'(sb_err), 32'd0);
        issue(5'd5);
        chk("over_err", 32'(sb_err), 32'd1);
        chk("over_full", 32'(lo_full), 32'd1);
        probe("over_x5", 5'd5, 1'b0);
        done(5'd4);
        chk("d4_full", 32'(lo_full), 32'd0);
        probe("d4_x4", 5'd4, 1'b0);

        // Same-register issue and done cancel.
        lo_issue   = 1'b1;
        lo_rd      = 5'd1;
        lo_done    = 1'b1;
        lo_done_rd = 5'd1;
        tick();
        clr();
        probe("same_x1", 5'd1, 1'b1);
        chk("same_full", 32'(lo_full), 32'd0);
        issue(5'd2);
        chk("same_out", 32'(lo_full), 32'd1);

        // Done does not free a slot for a same-cycle issue.
        lo_issue   = 1'b1;
        lo_rd      = 5'd6;
        lo_done    = 1'b1;
        lo_done_rd = 5'd2;
        tick();
        clr();
        chk("pre_full", 32'(lo_full), 32'd0);
        probe("pre_x6", 5'd6, 1'b0);
        probe("pre_x2", 5'd2, 1'b1);
        done(5'd1);
        probe("d1_x1", 5'd1, 1'b0);

        // x0 is never forwarded, stalled on or counted.
        ex_valid     = 1'b1;
        ex_rs_used   = 2'b01;
        stg_wr_en    = 2'b01;
        stg_data_rdy = 2'b00;
        lo_issue     = 1'b1;
        lo_rd        = 5'd0;
        #1;
        chk("x0_sel", 32'(fwd_sel), 32'h0);
        chk("x0_stall", 32'(stall), 32'd0);
        tick();
        clr();
        issue(5'd7);
        chk("x0_out", 32'(lo_full), 32'd0);
        issue(5'd8);
        chk("x0_full", 32'(lo_full), 32'd1);

        // Reset mid-stream.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_err", 32'(sb_err), 32'd0);
        chk("rst2_full", 32'(lo_full), 32'd0);
        chk("rst2_cnt", stall_cnt, 32'd0);
        issue(5'd6);
        issue(5'd6);
        ex_valid   = 1'b1;
        ex_rs[0]   = 5'd6;
        ex_rs_used = 2'b01;
        #1;
        chk("rst3_pre", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst3_in", 32'(stall), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst3_post", 32'(stall), 32'd0);
        chk("rst3_cnt", stall_cnt, 32'd0);
        clr();
        done(5'd6);
        chk("rst3_err", 32'(sb_err), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
